// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready stage register with a two-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_STALL_CNT_EN to add a saturating back-pressure cycle counter on stall_cnt.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

  if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("pipe_stage_reg: WIDTH and CNT_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_s;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Handshake outputs are registered alongside the state so in_ready never sees out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_m         <= RESET_VALUE;
      r_s         <= RESET_VALUE;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_m         <= in_data;
            r_state     <= FULL;
            r_out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (w_in_xfer && w_out_xfer) begin
            r_m <= in_data;
          end else if (w_out_xfer) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end else if (w_in_xfer) begin
            r_s        <= in_data;
            r_state    <= SKID;
            r_in_ready <= 1'b0;
          end
        end
        SKID: begin
          if (w_out_xfer) begin
            r_m        <= r_s;
            r_state    <= FULL;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_m;

`ifdef PIPE_STAGE_STALL_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [CNT_WIDTH-1:0] r_stall_cnt;

  // Saturates at all-ones; only rst clears it, flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + random bench for pipe_stage_reg with a queue scoreboard of accepted beats.
module tb_pipe_stage_reg;

  localparam int unsigned TB_CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [TB_CNT_W-1:0] stall_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] sb[$];
  bit last_in_xfer = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH       (32),
    .RESET_VALUE (32'h0),
    .CNT_WIDTH   (TB_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called one time unit after a rising edge: score this cycle's transfers, then advance one cycle.
  task automatic cycle();
    bit ix;
    bit ox;
    ix = in_valid && in_ready;
    ox = out_valid && out_ready;
    if (flush) begin
      sb.delete();
    end else begin
      if (ox) begin
        if (sb.size() == 0) chk("unexpected_beat", {31'b0, out_valid}, 32'h0);
        else                chk("sb_data", out_data, sb.pop_front());
      end
      if (ix) sb.push_back(in_data);
    end
    last_in_xfer = ix;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 10; k++) begin
      if (out_valid) cycle();
    end
    chk(tag, {31'b0, out_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] stream [3];
    stream = '{32'h11, 32'h22, 32'h33};

    // Reset values, applied asynchronously before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'h1);
    chk("rst_out_data",  out_data,           32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full-rate stream, one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = stream[i];
      chk("stream_in_ready", {31'b0, in_ready}, 32'h1);
      cycle();
      chk("stream_out_valid", {31'b0, out_valid}, 32'h1);
      chk("stream_out_data",  out_data,           stream[i]);
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_idle", {31'b0, out_valid}, 32'h0);

    // Back-pressure fills M then S, third beat held upstream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA1;
    cycle();
    in_data = 32'hA2;
    chk("bp_ready_full", {31'b0, in_ready}, 32'h1);
    cycle();
    chk("bp_ready_skid", {31'b0, in_ready}, 32'h0);
    chk("bp_m_a1",       out_data,          32'hA1);
    in_data = 32'hA3;
    cycle();
    cycle();
    chk("bp_ready_held", {31'b0, in_ready}, 32'h0);
    chk("bp_m_held",     out_data,          32'hA1);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && in_valid; k++) begin
      cycle();
      if (last_in_xfer) in_valid = 1'b0;
    end
    chk("bp_a3_accepted", {31'b0, in_valid}, 32'h0);
    drain("bp_drain");
    chk("bp_none_lost", sb.size(), 32'h0);

    // Flush while in SKID drops M, S and the offered beat
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    cycle();
    in_data = 32'h6;
    cycle();
    chk("fl_skid_ready", {31'b0, in_ready}, 32'h0);
    flush   = 1'b1;
    in_data = 32'h7;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", {31'b0, out_valid}, 32'h0);
    chk("fl_in_ready",  {31'b0, in_ready},  32'h1);
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("fl_no_output", {31'b0, out_valid}, 32'h0);

    // Simultaneous in/out transfer in FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1234;
    cycle();
    in_data   = 32'hBEEF;
    out_ready = 1'b1;
    cycle();
    chk("both_out_data",  out_data,           32'hBEEF);
    chk("both_out_valid", {31'b0, out_valid}, 32'h1);
    chk("both_in_ready",  {31'b0, in_ready},  32'h1);
    in_valid = 1'b0;
    drain("both_drain");

    // Asynchronous reset between edges while in SKID
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1;
    cycle();
    in_data = 32'h2;
    cycle();
    in_valid = 1'b0;
    chk("ar_skid_ready", {31'b0, in_ready}, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", {31'b0, out_valid}, 32'h0);
    chk("ar_in_ready",  {31'b0, in_ready},  32'h1);
    chk("ar_out_data",  out_data,           32'h0);
    sb.delete();
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("ar_nothing_emitted", {31'b0, out_valid}, 32'h0);

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Stall counter saturation, survives flush, cleared by reset
    chk("sc_after_rst", {28'b0, stall_cnt}, 32'h0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h9;
    cycle();
    in_valid = 1'b0;
    repeat (5) cycle();
    chk("sc_count5", {28'b0, stall_cnt}, 32'h5);
    repeat (15) cycle();
    chk("sc_saturate", {28'b0, stall_cnt}, 32'hF);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("sc_flush_keeps", {28'b0, stall_cnt}, 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("sc_rst_clears", {28'b0, stall_cnt}, 32'h0);
    #1 rst = 1'b0;
`endif

    // Random valid/ready traffic against the scoreboard
    for (int i = 0; i < 200; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 32'h1000 + i;
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("rnd_drain");
    chk("rnd_none_lost", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
